// File: rtl/maze_pkg.sv
// Shared types and digit limits for the maze game MM:SS elapsed-time counter.
package maze_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    FULL = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit counting 0..MAX; carry_out asserts when an increment wraps it.
module bcd_digit
  import maze_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inc,
  input  logic               clear,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == MAX) ? '0 : value + DIGIT_W'(1);
    end
  end

  assign carry_out = inc && (value == MAX);

endmodule

// File: rtl/maze_timer.sv
// MM:SS elapsed-time counter with start/stop/clear control and a seconds prescaler.
// Define MAZE_TIMER_SATURATE_EN to stop at 59:59 (FULL state) instead of wrapping to 00:00.
module maze_timer
  import maze_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int TICK_HZ    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               running,
  output logic               at_max,
  output logic               tick
);

  localparam int DIV   = CLOCK_FREQ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);

  state_t             state, state_next;
  logic [PRE_W-1:0]   pre, pre_next;
  logic               inc_en;
  logic               clear_digits;
  logic               terminal;
  logic               count_full;
  logic               at_max_next;
  logic               c_sec_ones, c_sec_tens, c_min_ones, wrap;

  assign terminal   = (pre == PRE_W'(DIV - 1));
  assign count_full = (sec_ones == SEC_ONES_MAX) && (sec_tens == SEC_TENS_MAX) &&
                      (min_ones == MIN_ONES_MAX) && (min_tens == MIN_TENS_MAX);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    pre_next     = pre;
    inc_en       = 1'b0;
    clear_digits = 1'b0;
    if (clear) begin
      state_next   = IDLE;
      pre_next     = '0;
      clear_digits = 1'b1;
    end else if (stop) begin
      // Stop also masks a simultaneous start, and freezes the prescaler even on terminal count.
      if (state == RUN) state_next = HOLD;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_next = RUN;
          pre_next   = '0;
        end
        HOLD: if (start) state_next = RUN;
        RUN: begin
          if (terminal) begin
            pre_next = '0;
`ifdef MAZE_TIMER_SATURATE_EN
            if (count_full) state_next = FULL;
            else            inc_en     = 1'b1;
`else
            inc_en = 1'b1;
`endif
          end else begin
            pre_next = pre + PRE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAZE_TIMER_SATURATE_EN
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign at_max_next = (state_next == FULL);
`else
  assign at_max_next = wrap && count_full;
`endif

  // NOTE: reset is synchronous, so it is just the highest-priority branch inside the clocked block.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      pre     <= '0;
      running <= 1'b0;
      at_max  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_next;
      pre     <= pre_next;
      running <= (state_next == RUN);
      at_max  <= at_max_next;
      tick    <= inc_en;
    end
  end

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clock(clock), .reset_n(reset_n), .inc(inc_en), .clear(clear_digits),
    .value(sec_ones), .carry_out(c_sec_ones)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock(clock), .reset_n(reset_n), .inc(c_sec_ones), .clear(clear_digits),
    .value(sec_tens), .carry_out(c_sec_tens)
  );

  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clock(clock), .reset_n(reset_n), .inc(c_sec_tens), .clear(clear_digits),
    .value(min_ones), .carry_out(c_min_ones)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clock(clock), .reset_n(reset_n), .inc(c_min_ones), .clear(clear_digits),
    .value(min_tens), .carry_out(wrap)
  );

endmodule

// File: tb/tb_maze_timer.sv
// Directed self-checking bench for maze_timer with DIV = 10; honours MAZE_TIMER_SATURATE_EN.
module tb_maze_timer;
  import maze_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               start, stop, clear;
  logic [DIGIT_W-1:0] sec_ones, sec_tens, min_ones, min_tens;
  logic               running, at_max, tick;

  int n_checks = 0;
  int n_fail   = 0;

  maze_timer #(.CLOCK_FREQ(10), .TICK_HZ(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .at_max(at_max), .tick(tick)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected display for a count of elapsed seconds, packed {mm_tens, mm_ones, ss_tens, ss_ones}.
  function automatic logic [31:0] mmss(input int secs);
    int m, s;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {16'h0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [31:0] digits();
    return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Caller is always just after a falling edge; this advances n rising edges.
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    @(negedge clock);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    wait_edges(2);
    check("reset_digits", digits(), 0);
    check("reset_running", running, 0);
    check("reset_tick", tick, 0);
    check("reset_at_max", at_max, 0);
    reset_n = 1'b1;
    wait_edges(3);
    check("idle_no_count", digits(), 0);

    // First second arrives exactly DIV edges after start, then every DIV edges.
    pulse(1, 0, 0);
    check("start_running", running, 1);
    check("start_no_tick", tick, 0);
    for (int s = 1; s <= 10; s++) begin
      wait_edges(9);
      check("pre_tick_quiet", tick, 0);
      wait_edges(1);
      check("tick_pulse", tick, 1);
      check("count_seconds", digits(), mmss(s));
    end

    // Reset while running at 03:27, with start held to show reset dominates.
    wait_edges(1970);
    check("at_0327", digits(), mmss(207));
    reset_n = 1'b0; start = 1'b1;
    @(negedge clock);
    check("midreset_digits", digits(), 0);
    check("midreset_running", running, 0);
    check("midreset_tick", tick, 0);
    reset_n = 1'b1; start = 1'b0;
    wait_edges(15);
    check("after_reset_idle", digits(), 0);
    check("after_reset_notrun", running, 0);

    // Pause at 00:04 + prescaler 6; the resume increment is 4 edges later.
    pulse(1, 0, 0);
    wait_edges(46);
    check("hold_pre", digits(), mmss(4));
    pulse(0, 1, 0);
    check("hold_running", running, 0);
    for (int i = 0; i < 50; i++) begin
      check("hold_digits", digits(), mmss(4));
      check("hold_tick", tick, 0);
      wait_edges(1);
    end
    pulse(1, 0, 0);
    check("resume_running", running, 1);
    wait_edges(3);
    check("resume_wait", digits(), mmss(4));
    check("resume_wait_tick", tick, 0);
    wait_edges(1);
    check("resume_inc", digits(), mmss(5));
    check("resume_tick", tick, 1);

    // start+stop together in RUN -> HOLD; clear+start together -> IDLE.
    pulse(1, 1, 0);
    check("startstop_hold", running, 0);
    wait_edges(20);
    check("startstop_frozen", digits(), mmss(5));
    pulse(1, 0, 1);
    check("clearstart_digits", digits(), 0);
    check("clearstart_running", running, 0);
    wait_edges(12);
    check("clearstart_idle", digits(), 0);

    // Stop on the terminal-count edge suppresses the increment; resume increments one edge later.
    pulse(1, 0, 0);
    wait_edges(9);
    pulse(0, 1, 0);
    check("stop_tc_digits", digits(), 0);
    check("stop_tc_tick", tick, 0);
    pulse(1, 0, 0);
    check("stop_tc_resume0", digits(), 0);
    wait_edges(1);
    check("stop_tc_resume1", digits(), mmss(1));
    check("stop_tc_resume_tick", tick, 1);

    // Clear on the terminal-count edge: no increment and no tick.
    wait_edges(9);
    pulse(0, 0, 1);
    check("clear_tc_digits", digits(), 0);
    check("clear_tc_tick", tick, 0);
    check("clear_tc_running", running, 0);

    // Full carry ripple 09:59 -> 10:00 in a single edge.
    pulse(1, 0, 0);
    wait_edges(5990);
    check("at_0959", digits(), mmss(599));
    wait_edges(9);
    check("pre_carry", digits(), mmss(599));
    check("pre_carry_tick", tick, 0);
    wait_edges(1);
    check("carry_1000", digits(), mmss(600));
    check("carry_tick", tick, 1);

    // End of range.
    wait_edges(29990);
    check("at_5959", digits(), mmss(3599));
    check("at_5959_at_max", at_max, 0);
    wait_edges(9);
    check("pre_end_tick", tick, 0);
    wait_edges(1);
`ifdef MAZE_TIMER_SATURATE_EN
    check("sat_digits", digits(), mmss(3599));
    check("sat_tick", tick, 0);
    check("sat_at_max", at_max, 1);
    check("sat_running", running, 0);
    for (int i = 0; i < 30; i++) begin
      wait_edges(1);
      check("sat_hold_tick", tick, 0);
      check("sat_hold_at_max", at_max, 1);
    end
    pulse(1, 0, 0);
    check("sat_start_ignored", running, 0);
    wait_edges(20);
    check("sat_still_full", digits(), mmss(3599));
    check("sat_still_at_max", at_max, 1);
    pulse(0, 0, 1);
    check("sat_clear_digits", digits(), 0);
    check("sat_clear_at_max", at_max, 0);
`else
    check("wrap_digits", digits(), 0);
    check("wrap_tick", tick, 1);
    check("wrap_at_max", at_max, 1);
    check("wrap_running", running, 1);
    wait_edges(1);
    check("wrap_tick_drop", tick, 0);
    check("wrap_at_max_drop", at_max, 0);
    wait_edges(9);
    check("wrap_next_sec", digits(), mmss(1));
    check("wrap_next_at_max", at_max, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_timer.md
# maze_timer

Elapsed-time counter for the maze game. It divides the system clock into a seconds tick and keeps an MM:SS count as four BCD digits, which feed directly into the four seven-segment digit decoders. It accepts start, stop and clear pulses from the game control logic, and reports a running flag and an end-of-range flag back to it.

## Interface
- CLOCK_FREQ, 50_000_000: system clock frequency in Hz.
- TICK_HZ, 1: count increment rate in Hz. DIV = CLOCK_FREQ / TICK_HZ, which must be an integer ≥ 2.
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse: begin or resume counting.
- stop  in  1  one-cycle pulse: pause counting.
- clear  in  1  one-cycle pulse: zero the count and return to idle.
- sec_ones  out  4  BCD digit 0–9.
- sec_tens  out  4  BCD digit 0–5.
- min_ones  out  4  BCD digit 0–9.
- min_tens  out  4  BCD digit 0–5.
- running  out  1  high while in RUN.
- at_max  out  1  end-of-range indication (see Configuration).
- tick  out  1  one-cycle pulse, high in the cycle the digits show a new value.

## Operation
- States:
  - IDLE: count is 00:00.
  - RUN: counting.
  - HOLD: paused, count retained.
  - FULL: 59:59 reached (exists only with the macro).
- Control priority in any cycle: clear > stop > start.
- clear, from any state: all digits go to 0, the prescaler goes to 0, state goes to IDLE.
- start:
  - In IDLE: go to RUN with the prescaler at 0.
  - In HOLD: go to RUN with the prescaler value kept.
  - In RUN or FULL: ignored.
- stop:
  - In RUN: go to HOLD and freeze the prescaler.
  - In IDLE, HOLD or FULL: ignored.
- start and stop in the same cycle: stop wins. In IDLE that pair is a no-op.
- Prescaler:
  - Counts 0..DIV-1, and only while in RUN.
  - A terminal-count edge (prescaler == DIV-1) wraps it to 0 and increments the count.
- Count increment is a BCD ripple:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - min_tens 5→0 is the end-of-range event.
- Digits never hold a non-BCD value. Values 10–15 are unreachable.
- running = (state == RUN), registered.

## Timing
- Reset values: all digits 0, running 0, at_max 0, tick 0, state IDLE, prescaler 0.
- reset_n low overrides all other inputs on that edge, including mid-count.
- If start is sampled at edge E0:
  - running is high after E0.
  - The first increment is visible after edge E0+DIV.
  - Later increments follow every DIV edges while in RUN.
- tick is registered and aligns exactly with the digit change: high for the one cycle following the updating edge.
- Time spent in HOLD does not count.
  - Example: stop at prescaler value p, then resume. The next increment comes DIV-p edges after the resuming start.
- stop on a terminal-count edge: the increment is suppressed and the prescaler freezes at DIV-1.
- clear on a terminal-count edge: no increment and no tick.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- MAZE_TIMER_SATURATE_EN defined:
  - The increment from 59:59 is suppressed: the count stays 59:59 and state goes to FULL.
  - at_max is a level, high exactly while in FULL.
  - No tick is issued on that edge.
  - FULL is left only by clear or reset.
- MAZE_TIMER_SATURATE_EN undefined:
  - 59:59 wraps to 00:00 and state stays RUN.
  - tick fires normally on the wrap.
  - at_max pulses high for the same single cycle as that tick.
  - FULL is not implemented.

## Structure
- Shared package maze_pkg holds:
  - the state enum (IDLE, RUN, HOLD, FULL);
  - DIGIT_W = 4;
  - SEC_ONES_MAX = 9, SEC_TENS_MAX = 5, MIN_ONES_MAX = 9, MIN_TENS_MAX = 5.
- Sub-module bcd_digit, one per digit, four instances cascaded:
  - Registered mod-(MAX+1) counter with inc/clear inputs.
  - Combinational carry_out = inc && (value == MAX).
- The top level holds the FSM, the prescaler, and tick/at_max generation.

## Test plan
All scenarios use CLOCK_FREQ=10, TICK_HZ=1, so DIV=10.

- Reset mid-count at 03:27 in RUN → all digits 0, running 0, tick 0, state IDLE on the next edge.
- start at E0 → running after E0, tick high after E0+10, E0+20, ….
  - sec_ones 1, 2, …, 9, then 0 with sec_tens 1 after E0+100.
- Run to 00:04 plus prescaler 6, then stop, wait 50 cycles, then start.
  - Count holds at 00:04 throughout HOLD.
  - The next increment is 4 edges after the resuming start.
- start and stop in the same cycle in RUN → HOLD. clear and start in the same cycle → IDLE at 00:00.
- Carry chain: run from 09:59 → 10:00 on one tick. No intermediate digit values are visible.
- End of range at 59:59:
  - With the macro: the count stays 59:59, at_max is a steady 1, no further ticks, and start is ignored until clear.
  - Without the macro: the count goes to 00:00, tick and at_max are high together for one cycle, and running stays 1.
